avago28_cdc_req_tx: RTL and testbench



---
 rtl/avago28_cdc_pkg.sv | 14 +
 rtl/avago28_3xsync_flop.sv | 24 ++
 rtl/avago28_cdc_req_tx.sv | 102 ++++++++++
 tb/tb_avago28_cdc_req_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avago28_cdc_pkg.sv
// Shared types and constants for the avago28 req/ack source-side CDC controller.
package avago28_cdc_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_REQ_HI = 2'd2,
    ST_REQ_LO = 2'd3
  } state_e;

  localparam int SYNC_STAGES = 3;
  localparam int INIT_CYCLES = 3;

endpackage

// File: rtl/avago28_3xsync_flop.sv
// Plain multi-stage flop synchronizer for signals entering the local clock domain.
module avago28_3xsync_flop #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  import avago28_cdc_pkg::*;

  logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];

  // NOTE: the synchronizer flops carry no reset on purpose; the parent flushes
  // them by waiting out SYNC_STAGES cycles after reset instead.
  always_ff @(posedge clk) begin
    stage[0] <= d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/avago28_cdc_req_tx.sv
// Source side of a four-phase req/ack word transfer: accepts a word, holds it on the
// launch register, raises req, waits for synchronized ack, then returns to zero.
module avago28_cdc_req_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_W  = 10
) (
  input  logic                  srcclk,
  input  logic                  srcrst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack_async,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);
  import avago28_cdc_pkg::*;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  state_e               state;
  state_e               state_nxt;
  logic [1:0]           init_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 ack_s;
  logic                 accept;
  logic                 waiting;
  logic                 state_chg;
  logic                 wd_hit;

  avago28_3xsync_flop #(
    .DATA_WIDTH(1)
  ) u_ack_sync (
    .clk(srcclk),
    .d  (xfer_ack_async),
    .q  (ack_s)
  );

  // A destination still holding ack high from a truncated handshake blocks new words.
  assign in_ready  = (state == ST_IDLE) && !ack_s;
  assign busy      = (state != ST_IDLE);
  assign accept    = in_ready && in_valid;
  assign waiting   = (state == ST_REQ_HI) || (state == ST_REQ_LO);
  assign state_chg = (state_nxt != state);
  assign wd_hit    = waiting && !state_chg && (wd_cnt == WD_MAX - TIMEOUT_W'(1));

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (init_cnt == 2'(INIT_CYCLES - 1)) state_nxt = ST_IDLE;
      ST_IDLE:   if (accept)                          state_nxt = ST_REQ_HI;
      ST_REQ_HI: if (ack_s)                           state_nxt = ST_REQ_LO;
      ST_REQ_LO: if (!ack_s)                          state_nxt = ST_IDLE;
      default:                                        state_nxt = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge srcclk or negedge srcrst_n) begin
    if (!srcrst_n) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 2'd1;
      end

      if (accept) begin
        xfer_data <= in_data;
        xfer_req  <= 1'b1;
      end else if ((state == ST_REQ_HI) && ack_s) begin
        xfer_req <= 1'b0;
      end

      if (state_chg) begin
        wd_cnt <= '0;
      end else if (waiting && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      end

      // The flag sets only on the step into all-ones, so a clear while the
      // counter sits saturated stays cleared; a coincident set beats the clear.
      if (wd_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avago28_cdc_req_tx.sv
// Scoreboard bench: accepted words are queued by the driver and popped by a monitor
// on each req rise; directed phases check handshake timing, watchdog and reset.
module tb_avago28_cdc_req_tx;

  localparam int DW   = 32;
  localparam int TW   = 4;
  localparam int SYNC = 3;

  logic          srcclk = 1'b0;
  logic          srcrst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack_async;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  logic rsp_ack  = 1'b0;
  int   rsp_cnt  = 0;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_word     = '0;
  logic          mon_prev_req = 1'b0;
  int            mon_pulses   = 0;

  assign xfer_ack_async = auto_ack ? rsp_ack : man_ack;

  always #5 srcclk = ~srcclk;

  avago28_cdc_req_tx #(
    .DATA_WIDTH(DW),
    .TIMEOUT_W (TW)
  ) dut (
    .srcclk        (srcclk),
    .srcrst_n      (srcrst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .xfer_req      (xfer_req),
    .xfer_data     (xfer_data),
    .xfer_ack_async(xfer_ack_async),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination model: ack follows req after a random number of cycles.
  always @(negedge srcclk) begin
    if (!auto_ack) begin
      rsp_ack = 1'b0;
      rsp_cnt = 0;
    end else if (rsp_ack == xfer_req) begin
      rsp_cnt = int'($urandom_range(0, 4));
    end else if (rsp_cnt == 0) begin
      rsp_ack = xfer_req;
    end else begin
      rsp_cnt--;
    end
  end

  // Monitor: every req rise must match the oldest accepted word, and the launch
  // register must show the most recently launched word on every cycle.
  always @(negedge srcclk) begin
    if (!srcrst_n) begin
      mon_prev_req = 1'b0;
      mon_word     = '0;
    end else begin
      if (xfer_req && !mon_prev_req) begin
        mon_pulses++;
        check("req_has_accept", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) mon_word = exp_q.pop_front();
      end
      check("xfer_data_hold", 64'(xfer_data), 64'(mon_word));
      mon_prev_req = xfer_req;
    end
  end

  task automatic tick();
    @(posedge srcclk);
    #1;
  endtask

  // Offers a word and leaves in_valid high; returns 1 ns after the accepting edge.
  task automatic send(input logic [DW-1:0] w);
    logic ok;
    logic rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 200 && !ok; t++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        exp_q.push_back(w);
      end
    end
    check("accept_in_time", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int t = 0; t < max_cyc && (busy || xfer_req); t++) tick();
    check("idle_reached", 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    srcrst_n = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_xfer_req",    64'(xfer_req),    64'(0));
    check("rst_xfer_data",   64'(xfer_data),   64'(0));
    check("rst_in_ready",    64'(in_ready),    64'(0));
    check("rst_busy",        64'(busy),        64'(1));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));

    // Reset release: in_ready low for exactly SYNC cycles
    srcrst_n = 1'b1;
    check("init_ready_0", 64'(in_ready), 64'(0));
    for (int k = 1; k <= SYNC; k++) begin
      tick();
      check("init_ready", 64'(in_ready), 64'(k == SYNC));
      check("init_busy",  64'(busy),     64'(k < SYNC));
    end

    // Single transfer, ack raised 5 cycles after req
    send(32'hDEAD_BEEF);
    in_valid = 1'b0;
    check("single_req",   64'(xfer_req),  64'(1));
    check("single_data",  64'(xfer_data), 64'(32'hDEAD_BEEF));
    check("single_ready", 64'(in_ready),  64'(0));
    repeat (5) tick();
    man_ack = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      check("req_fall_timing", 64'(xfer_req), 64'(k <= SYNC));
    end
    repeat (2) tick();
    check("req_lo_busy", 64'(busy), 64'(1));
    man_ack = 1'b0;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      check("ready_return_timing", 64'(in_ready), 64'(k == SYNC + 1));
    end

    // Back-to-back words with in_valid held and an automatic responder
    auto_ack = 1'b1;
    p0 = mon_pulses;
    send(32'hAAAA_0001);
    send(32'hBBBB_0002);
    send(32'hCCCC_0003);
    send(32'hDDDD_0004);
    in_valid = 1'b0;
    wait_idle(100);
    check("b2b_pulses", 64'(mon_pulses - p0), 64'(4));
    auto_ack = 1'b0;
    tick();

    // Watchdog: ack withheld, flag sets on the 15th edge in REQ_HI
    send(32'h1234_5678);
    in_valid = 1'b0;
    for (int k = 1; k <= (1 << TW); k++) begin
      tick();
      check("wd_set_timing", 64'(timeout_err), 64'(k >= (1 << TW) - 1));
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd_clear", 64'(timeout_err), 64'(0));
    repeat (4) begin
      tick();
      check("wd_stays_clear", 64'(timeout_err), 64'(0));
    end
    man_ack = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      check("late_ack_req_fall", 64'(xfer_req), 64'(k <= SYNC));
    end
    // In REQ_LO with clear held: the set edge still wins, the next edge clears
    err_clr = 1'b1;
    for (int k = 1; k <= (1 << TW); k++) begin
      tick();
      check("wd_set_beats_clr", 64'(timeout_err), 64'(k == (1 << TW) - 1));
    end
    err_clr = 1'b0;
    man_ack = 1'b0;
    wait_idle(20);
    check("wd_after_done", 64'(timeout_err), 64'(0));

    // Async reset during REQ_HI, ack already high at the destination
    send(32'h0BAD_F00D);
    in_valid = 1'b0;
    tick();
    man_ack = 1'b1;
    tick();
    check("pre_rst_req", 64'(xfer_req), 64'(1));
    #2 srcrst_n = 1'b0;
    #1;
    check("async_rst_req",   64'(xfer_req),  64'(0));
    check("async_rst_busy",  64'(busy),      64'(1));
    check("async_rst_ready", 64'(in_ready),  64'(0));
    check("async_rst_data",  64'(xfer_data), 64'(0));
    tick();
    srcrst_n = 1'b1;

    // Stale ack: INIT then IDLE with in_ready held low, in_valid pulses ignored
    in_data = 32'h5A5A_5A5A;
    for (int k = 1; k <= 10; k++) begin
      in_valid = k[0];
      tick();
      check("stale_ready", 64'(in_ready), 64'(0));
      check("stale_req",   64'(xfer_req), 64'(0));
      check("stale_busy",  64'(busy),     64'(k < SYNC));
    end
    in_valid = 1'b0;
    man_ack  = 1'b0;
    for (int k = 1; k <= SYNC; k++) begin
      tick();
      check("stale_release", 64'(in_ready), 64'(k == SYNC));
    end
    auto_ack = 1'b1;
    send(32'hCAFE_0000);
    in_valid = 1'b0;
    wait_idle(50);

    // Randomized traffic with random gaps and responder delays
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      send($urandom);
    end
    in_valid = 1'b0;
    wait_idle(100);
    check("rand_no_timeout", 64'(timeout_err), 64'(0));
    check("queue_drained",   64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
